traffic_light: RTL and testbench
================================

TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 SHALL have parameter RED_TIME, default 5: clock cycles the RED phase lasts (legal 1..255).
REQ-002 SHALL have parameter GREEN_TIME, default 4: clock cycles the GREEN phase lasts (legal 1..255).
REQ-003 SHALL have parameter YELLOW_TIME, default 2: clock cycles the YELLOW phase lasts (legal 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port red, output, 1 bit: red lamp on.
REQ-007 SHALL have port yellow, output, 1 bit: yellow lamp on.
REQ-008 SHALL have port green, output, 1 bit: green lamp on.

Function
REQ-009 SHALL implement a 3-state FSM: RED -> GREEN -> YELLOW -> RED, repeating indefinitely with no other transitions.
REQ-010 SHALL hold a phase counter, cleared to 0 on every phase entry.
REQ-011 On each rising clk with rst low: if counter == duration(current state)-1, advance state and clear counter; else increment counter.
REQ-012 Each phase SHALL therefore last exactly its parameter value in clock cycles; default full period is 11 cycles.
REQ-013 Outputs SHALL be decoded only from the state register, never from the counter (no glitch on counter wrap).
REQ-014 Exactly one of red/yellow/green SHALL be 1 at all times, including during and immediately after reset.
REQ-015 Duration value 1 SHALL give a one-cycle phase; the counter SHALL never exceed 254.
REQ-016 Unused state encoding SHALL transition to RED with counter 0 on the next edge; outputs SHALL show red while in it.
REQ-017 Counter width SHALL be 8 bits.

Reset
REQ-018 rst high SHALL immediately (no clock needed) force state RED, counter 0, outputs red=1, yellow=0, green=0.
REQ-019 Reset asserted mid-phase SHALL abort the phase; after release RED SHALL last the full RED_TIME cycles.
REQ-020 The first rising edge with rst low SHALL count as RED cycle 1.

Configuration
REQ-021 With macro TRAFFIC_LIGHT_ASSERT_EN defined, the block SHALL include simulation assertions: lamps one-hot every cycle, and legal transition order only; assertion failure reports via $error.
REQ-022 Without TRAFFIC_LIGHT_ASSERT_EN, no assertion code SHALL be compiled; functional behaviour SHALL be identical.

Structure
REQ-023 Package traffic_light_pkg SHALL hold the state typedef (RED=2'b00, GREEN=2'b01, YELLOW=2'b10) and default duration constants.
REQ-024 The phase counter SHALL be a sub-module traffic_light_timer (inputs clk, rst, load-clear, terminal value; output done).
REQ-025 The FSM and output decode SHALL reside in traffic_light.

Verification (clk period 10 ns, rising edges at 5, 15, 25 ns...)
REQ-026 rst=1 at t=0, no clock edge yet -> red=1, yellow=0, green=0.
REQ-027 Defaults, rst released at 10 ns -> red until the 55 ns edge, green 55-95 ns, yellow 95-115 ns, red again from 115 ns.
REQ-028 Run 33 cycles after release -> pattern repeats with period 11 cycles (5 red/4 green/2 yellow); one-hot in every cycle.
REQ-029 rst pulsed high during GREEN (e.g., at 70 ns, released at 80 ns) -> red=1 at 70 ns without a clock edge; green next at the fifth edge after 80 ns (125 ns).
REQ-030 RED_TIME=GREEN_TIME=YELLOW_TIME=1 -> lamp changes on every rising edge: red, green, yellow, red...
REQ-031 Build with TRAFFIC_LIGHT_ASSERT_EN, run REQ-027 -> zero assertion failures.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and default phase lengths for the traffic light.
// Optional checks in traffic_light are enabled by TRAFFIC_LIGHT_ASSERT_EN.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned DEF_RED_TIME    = 5;
  localparam int unsigned DEF_GREEN_TIME  = 4;
  localparam int unsigned DEF_YELLOW_TIME = 2;

  function automatic state_t next_of(input state_t s);
    unique case (s)
      RED:     next_of = GREEN;
      GREEN:   next_of = YELLOW;
      default: next_of = RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// Phase counter: counts cycles within a phase, flags the last one.
// done is purely a compare, so clr must be asserted when done fires.
module traffic_light_timer
  import traffic_light_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign done = (cnt == term);

endmodule

// File: rtl/traffic_light.sv
// Three-phase traffic light FSM with lamp decode from state only.
// Define TRAFFIC_LIGHT_ASSERT_EN to compile one-hot/order checks.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_TIME    = DEF_RED_TIME,
  parameter int unsigned GREEN_TIME  = DEF_GREEN_TIME,
  parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME
) (
  input  logic clk,
  input  logic rst,
  output logic red,
  output logic yellow,
  output logic green
);

  localparam logic [CNT_W-1:0] RT = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GT = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YT = CNT_W'(YELLOW_TIME - 1);

  state_t           state;
  state_t           state_nx;
  logic             clr;
  logic             done;
  logic [CNT_W-1:0] term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RED;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    term     = RT;
    unique case (state)
      RED: begin
        term = RT;
        if (done) begin
          state_nx = GREEN;
          clr      = 1'b1;
        end
      end
      GREEN: begin
        term = GT;
        if (done) begin
          state_nx = YELLOW;
          clr      = 1'b1;
        end
      end
      YELLOW: begin
        term = YT;
        if (done) begin
          state_nx = RED;
          clr      = 1'b1;
        end
      end
      default: begin
        state_nx = RED;
        clr      = 1'b1;
      end
    endcase
  end

  // Unused encoding shows red, like reset does.
  always_comb begin
    red    = 1'b0;
    yellow = 1'b0;
    green  = 1'b0;
    unique case (state)
      GREEN:   green  = 1'b1;
      YELLOW:  yellow = 1'b1;
      default: red    = 1'b1;
    endcase
  end

  traffic_light_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .term (term),
    .done (done)
  );

`ifdef TRAFFIC_LIGHT_ASSERT_EN
  always_ff @(posedge clk) begin
    assert ($onehot({red, yellow, green}))
      else $error("traffic_light: lamps not one-hot");
    if (!rst) begin
      assert (state_nx == state || state_nx == next_of(state))
        else $error("traffic_light: illegal transition");
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench: default-timing DUT plus an all-ones-timing DUT.
// Stimulus queues expected lamps; the monitor pops and compares.
module tb_traffic_light;

  typedef struct {
    logic [2:0] lamps;
    bit         fast;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  logic a_red, a_yellow, a_green;
  logic b_red, b_yellow, b_green;

  exp_t q[$];
  event chk_ev;
  int   n_chk;
  int   n_fail;
  bit   done_f;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  traffic_light u_a (
    .clk    (clk),
    .rst    (rst),
    .red    (a_red),
    .yellow (a_yellow),
    .green  (a_green)
  );

  traffic_light #(
    .RED_TIME    (1),
    .GREEN_TIME  (1),
    .YELLOW_TIME (1)
  ) u_b (
    .clk    (clk),
    .rst    (rst),
    .red    (b_red),
    .yellow (b_yellow),
    .green  (b_green)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_def(input int n);
    logic [2:0] tbl [11];
    tbl = '{LR, LR, LR, LR, LR, LG, LG, LG, LG, LY, LY};
    return tbl[n % 11];
  endfunction

  function automatic logic [2:0] exp_fast(input int n);
    logic [2:0] tbl [3];
    tbl = '{LR, LG, LY};
    return tbl[n % 3];
  endfunction

  task automatic push(input logic [2:0] a, input logic [2:0] b,
                      input string nm);
    exp_t e;
    e.lamps = a;
    e.fast  = 1'b0;
    e.name  = {nm, "_def"};
    q.push_back(e);
    e.lamps = b;
    e.fast  = 1'b1;
    e.name  = {nm, "_fast"};
    q.push_back(e);
  endtask

  task automatic chk_now(input string nm);
    n_chk++;
    if ({a_red, a_yellow, a_green} !== LR ||
        {b_red, b_yellow, b_green} !== LR) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %b/%b expected %b",
               nm, $time, {a_red, a_yellow, a_green},
               {b_red, b_yellow, b_green}, LR);
    end
  endtask

  initial begin
    exp_t       e;
    logic [2:0] act;
    n_chk  = 0;
    n_fail = 0;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = e.fast ? {b_red, b_yellow, b_green}
                     : {a_red, a_yellow, a_green};
        n_chk++;
        if (act !== e.lamps) begin
          n_fail++;
          $display("FAIL %s t=%0t: lamps(ryg) got %b expected %b",
                   e.name, $time, act, e.lamps);
        end
      end
    end
  end

  initial begin
    done_f = 1'b0;
    #5000;
    if (!done_f) begin
      $display("FAIL timeout t=%0t: stimulus did not finish",
               $time);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    #1;
    chk_now("reset_t0_direct");
    push(LR, LR, "reset_t0");
    ->chk_ev;
    #9;
    rst = 1'b0;
    for (int n = 1; n <= 38; n++) begin
      @(posedge clk);
      #1;
      push(exp_def(n), exp_fast(n), $sformatf("run_c%0d", n));
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_now("async_rst_direct");
    push(LR, LR, "async_rst");
    ->chk_ev;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      push(exp_def(n), exp_fast(n), $sformatf("rerun_c%0d", n));
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain t=%0t: %0d expectations unchecked",
               $time, q.size());
    end
    done_f = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
